// File: rtl/trap_unit_pkg.sv
// trap_unit_pkg: core configuration, CSR types and exception constants shared by the trap controller.
package CoreConfig;
    localparam int PC_LEN = 32;
endpackage

package CSR_Pkg;
    typedef struct packed {
        logic [27:0] rsvd_hi;
        logic        mie;
        logic [2:0]  rsvd_lo;
    } mstatus_t;

    typedef struct packed {
        logic meie;
        logic mtie;
        logic msie;
    } mie_m_only_t;

    typedef struct packed {
        logic meip;
        logic mtip;
        logic msip;
    } mip_m_only_t;

    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } mtvec_t;

    typedef struct packed {
        logic        interrupt;
        logic [30:0] code;
    } mcause_t;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;
endpackage

package Exception_Pkg;
    import CSR_Pkg::*;

    // Wide enough for the largest external code (16 + 31).
    localparam int USED_CODE_LEN = 6;
    localparam int EXT_CAUSE_BASE_DEF = 16;
    localparam logic [USED_CODE_LEN-1:0] MSI_CODE = 6'd3;
    localparam logic [USED_CODE_LEN-1:0] MTI_CODE = 6'd7;

    typedef enum logic {IDLE, ARMED} trap_state_e;

    function automatic mcause_t PadCause(input logic intr, input logic [USED_CODE_LEN-1:0] code);
        return '{interrupt: intr, code: 31'(code)};
    endfunction
endpackage

// File: rtl/trap_unit_vector_gen.sv
// trap_vector_gen: interrupt priority select (MEI > MSI > MTI) and direct/vectored trap target.
module trap_vector_gen
    import Exception_Pkg::*;
    import CSR_Pkg::*;
#(
    parameter int EXT_ID_W       = 5,
    parameter int EXT_CAUSE_BASE = EXT_CAUSE_BASE_DEF,
    parameter bit MSI_EN         = 1'b1
) (
    input  mie_m_only_t              mie,
    input  mip_m_only_t              mip,
    input  logic [EXT_ID_W-1:0]      ext_irq_id,
    input  mtvec_t                   mtvec,
    input  logic                     is_interrupt,
    input  logic [USED_CODE_LEN-1:0] cause,
    output logic                     any_irq,
    output logic [USED_CODE_LEN-1:0] sel_code,
    output logic [31:0]              target
);
    logic [2:0] pend;
    logic [29:0] vec_base;

    assign pend = {mie.meie & mip.meip, mie.mtie & mip.mtip, MSI_EN & mie.msie & mip.msip};
    assign any_irq = |pend;
    assign sel_code = pend[2] ? USED_CODE_LEN'(EXT_CAUSE_BASE) + USED_CODE_LEN'(ext_irq_id)
                    : pend[0] ? MSI_CODE : MTI_CODE;
    // 30-bit sum deliberately wraps.
    assign vec_base = (mtvec.mode == MTVEC_VECTORED && is_interrupt) ? mtvec.base + 30'(cause) : mtvec.base;
    assign target = {vec_base, 2'b00};
endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap controller merging exceptions and interrupts at commit,
// with a two-state interrupt acceptance FSM and jump-shadow mepc tracking.
module trap_unit
    import Exception_Pkg::*;
    import CSR_Pkg::*;
#(
    parameter int PC_LEN         = CoreConfig::PC_LEN,
    parameter int EXT_ID_W       = 5,
    parameter int EXT_CAUSE_BASE = EXT_CAUSE_BASE_DEF,
    parameter bit MSI_EN         = 1'b1,
    parameter int JMP_WINDOW     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_n,
    input  logic                     flush,
    input  logic                     exc_raise,
    input  logic [USED_CODE_LEN-1:0] exc_code,
    input  logic [31:0]              exc_tval,
    input  logic [PC_LEN-1:0]        instr_addr_id_ex,
    input  logic                     jump_en_ex,
    input  logic [PC_LEN-1:0]        jump_addr_ex,
    input  mstatus_t                 csr_mstatus,
    input  mie_m_only_t              csr_mie,
    input  mip_m_only_t              csr_mip,
    input  mtvec_t                   csr_mtvec,
    input  logic [EXT_ID_W-1:0]      ext_irq_id,
    output logic                     any_interrupt_come,
    output logic                     int_flush_req,
    output logic                     trap_occurred,
    output logic                     trap_is_interrupt,
    output logic [PC_LEN-1:0]        new_mepc,
    output mcause_t                  new_mcause,
    output logic [31:0]              new_mtval,
    output logic [31:0]              trap_jump_addr
);
    trap_state_e state, state_d;
    logic [USED_CODE_LEN-1:0] cause_q, sel_code;
    logic [2:0] jmp_cnt;
    logic [PC_LEN-1:0] jmp_addr_q;
    logic take;
    logic unused_ok;

    // flush only matters upstream; a latched interrupt survives it.
    assign unused_ok = ^{flush, csr_mstatus.rsvd_hi, csr_mstatus.rsvd_lo};

    trap_vector_gen #(
        .EXT_ID_W      (EXT_ID_W),
        .EXT_CAUSE_BASE(EXT_CAUSE_BASE),
        .MSI_EN        (MSI_EN)
    ) u_vec (
        .mie         (csr_mie),
        .mip         (csr_mip),
        .ext_irq_id  (ext_irq_id),
        .mtvec       (csr_mtvec),
        .is_interrupt(trap_is_interrupt),
        .cause       (trap_is_interrupt ? cause_q : exc_code),
        .any_irq     (any_interrupt_come),
        .sel_code    (sel_code),
        .target      (trap_jump_addr)
    );

    always_comb begin
        state_d = state;
        int_flush_req = 1'b0;
        take = 1'b0;
        if (state == IDLE) begin
            int_flush_req = any_interrupt_come & csr_mstatus.mie & ~exc_raise;
            state_d = (int_flush_req && stall_n) ? ARMED : IDLE;
        end else begin
            take = stall_n & ~exc_raise;
            state_d = (stall_n || exc_raise) ? IDLE : ARMED;
        end
    end

    assign trap_occurred = exc_raise | take;
    assign trap_is_interrupt = take;
    assign new_mcause = trap_is_interrupt ? PadCause(1'b1, cause_q) : PadCause(1'b0, exc_code);
    assign new_mtval = trap_is_interrupt ? 32'h0 : exc_tval;
    assign new_mepc = (jmp_cnt != 3'd0) ? jmp_addr_q : instr_addr_id_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cause_q <= '0;
            jmp_cnt <= '0;
            jmp_addr_q <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && int_flush_req && stall_n)
                cause_q <= sel_code;
            if (trap_occurred)
                jmp_cnt <= '0;
            else if (jump_en_ex && stall_n) begin
                jmp_cnt <= 3'(JMP_WINDOW);
                jmp_addr_q <= jump_addr_ex;
            end else if (stall_n && jmp_cnt != 3'd0)
                jmp_cnt <= jmp_cnt - 3'd1;
        end
    end
endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed scoreboard bench for trap_unit.
module tb_trap_unit;
    import Exception_Pkg::*;
    import CSR_Pkg::*;

    logic clk = 1'b0;
    logic rst_n, stall_n, flush, exc_raise, jump_en_ex;
    logic [USED_CODE_LEN-1:0] exc_code;
    logic [31:0] exc_tval, pc, jump_addr_ex;
    mstatus_t mstatus;
    mie_m_only_t mie;
    mip_m_only_t mip;
    mtvec_t mtvec;
    logic [4:0] ext_irq_id;
    logic any_irq, ifr, to, ti;
    logic [31:0] mepc, mtval, tgt;
    mcause_t mcause;

    typedef struct {
        string tag;
        bit full;
        logic to, ti, ifr;
        logic [31:0] mcause, mepc, mtval, tgt;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_n(stall_n), .flush(flush),
        .exc_raise(exc_raise), .exc_code(exc_code), .exc_tval(exc_tval),
        .instr_addr_id_ex(pc), .jump_en_ex(jump_en_ex), .jump_addr_ex(jump_addr_ex),
        .csr_mstatus(mstatus), .csr_mie(mie), .csr_mip(mip), .csr_mtvec(mtvec),
        .ext_irq_id(ext_irq_id), .any_interrupt_come(any_irq), .int_flush_req(ifr),
        .trap_occurred(to), .trap_is_interrupt(ti), .new_mepc(mepc), .new_mcause(mcause),
        .new_mtval(mtval), .trap_jump_addr(tgt)
    );

    task automatic cmp(input string n, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", n, o, e);
        end
    endtask

    task automatic push(input string tag, input bit full, input logic t, input logic i, input logic f,
                        input logic [31:0] mc = 0, input logic [31:0] ep = 0,
                        input logic [31:0] tv = 0, input logic [31:0] tg = 0);
        exp_t e;
        e.tag = tag; e.full = full; e.to = t; e.ti = i; e.ifr = f;
        e.mcause = mc; e.mepc = ep; e.mtval = tv; e.tgt = tg;
        sb.push_back(e);
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".trap_occurred"}, 32'(to), 32'(e.to));
            cmp({e.tag, ".trap_is_interrupt"}, 32'(ti), 32'(e.ti));
            cmp({e.tag, ".int_flush_req"}, 32'(ifr), 32'(e.ifr));
            if (e.full) begin
                cmp({e.tag, ".mcause"}, mcause, e.mcause);
                cmp({e.tag, ".mepc"}, mepc, e.mepc);
                cmp({e.tag, ".mtval"}, mtval, e.mtval);
                cmp({e.tag, ".target"}, tgt, e.tgt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall_n = 1'b1; flush = 1'b0; exc_raise = 1'b0; exc_code = '0;
        exc_tval = '0; pc = 32'h40; jump_en_ex = 1'b0; jump_addr_ex = '0;
        mstatus = '0; mie = '0; mip = '0; mtvec = '{base: 30'h40, mode: 2'b00}; ext_irq_id = '0;
        push("reset", 0, 0, 0, 0); cyc();
        rst_n = 1'b1;
        // Exception, direct mode
        exc_raise = 1; exc_code = 2; exc_tval = 32'hDEADBEEF;
        push("exc", 1, 1, 0, 0, 32'h2, 32'h40, 32'hDEADBEEF, 32'h100); cyc();
        exc_raise = 0;
        // Timer interrupt, one-cycle acceptance
        mstatus.mie = 1; mie.mtie = 1; mip.mtip = 1;
        push("mti_req", 0, 0, 0, 1); cyc();
        push("mti_take", 1, 1, 1, 0, 32'h80000007, 32'h40, 32'h0, 32'h100); cyc();
        mip = '0; mie = '0;
        // Vectored MEI id 3 beats MTI
        mtvec.mode = 2'b01; mie = '{meie: 1, mtie: 1, msie: 0}; mip = '{meip: 1, mtip: 1, msip: 0}; ext_irq_id = 3;
        push("mei_req", 0, 0, 0, 1); cyc();
        push("mei_take", 1, 1, 1, 0, 32'h80000013, 32'h40, 32'h0, 32'h14C); cyc();
        mip = '0; mie = '0; ext_irq_id = 0;
        // MSI beats MTI, vectored
        mie = '{meie: 0, mtie: 1, msie: 1}; mip = '{meip: 0, mtip: 1, msip: 1};
        push("msi_req", 0, 0, 0, 1); cyc();
        push("msi_take", 1, 1, 1, 0, 32'h80000003, 32'h40, 32'h0, 32'h10C); cyc();
        mip = '0; mie = '0; mtvec.mode = 2'b00;
        // Jump shadow with interrupt
        pc = 32'h80; jump_en_ex = 1; jump_addr_ex = 32'h200;
        push("jmp", 0, 0, 0, 0); cyc();
        jump_en_ex = 0; pc = 32'h84; mie.mtie = 1; mip.mtip = 1;
        push("jmp_req", 0, 0, 0, 1); cyc();
        push("jmp_take", 1, 1, 1, 0, 32'h80000007, 32'h200, 32'h0, 32'h100); cyc();
        mip = '0;
        for (int i = 0; i < 3; i++) begin push("idle", 0, 0, 0, 0); cyc(); end
        pc = 32'h90; exc_raise = 1; exc_tval = 32'h1234;
        push("post_jmp_exc", 1, 1, 0, 0, 32'h2, 32'h90, 32'h1234, 32'h100); cyc();
        exc_raise = 0;
        // Window edge: last shadow cycle, then first cycle past it
        jump_en_ex = 1; jump_addr_ex = 32'h300; push("jmp2", 0, 0, 0, 0); cyc();
        jump_en_ex = 0; push("jmp2_idle", 0, 0, 0, 0); cyc();
        exc_raise = 1; push("win_last", 1, 1, 0, 0, 32'h2, 32'h300, 32'h1234, 32'h100); cyc();
        exc_raise = 0;
        jump_en_ex = 1; push("jmp3", 0, 0, 0, 0); cyc();
        jump_en_ex = 0; push("jmp3_idle1", 0, 0, 0, 0); cyc();
        push("jmp3_idle2", 0, 0, 0, 0); cyc();
        exc_raise = 1; push("win_over", 1, 1, 0, 0, 32'h2, 32'h90, 32'h1234, 32'h100); cyc();
        exc_raise = 0;
        // Exception pre-empts armed interrupt, which is retaken later
        mip.mtip = 1;
        push("ax_req", 0, 0, 0, 1); cyc();
        exc_raise = 1; exc_code = 5; exc_tval = 32'h55;
        push("ax_exc", 1, 1, 0, 0, 32'h5, 32'h90, 32'h55, 32'h100); cyc();
        exc_raise = 0;
        push("ax_rereq", 0, 0, 0, 1); cyc();
        push("ax_retake", 1, 1, 1, 0, 32'h80000007, 32'h90, 32'h0, 32'h100); cyc();
        mip = '0;
        // Stall holds ARMED; source drop does not cancel
        mip.mtip = 1;
        push("st_req", 0, 0, 0, 1); cyc();
        stall_n = 0; mip = '0;
        for (int i = 0; i < 4; i++) begin push("stalled", 0, 0, 0, 0); cyc(); end
        stall_n = 1;
        push("st_take", 1, 1, 1, 0, 32'h80000007, 32'h90, 32'h0, 32'h100); cyc();
        // Flush does not cancel ARMED
        mip.mtip = 1;
        push("fl_req", 0, 0, 0, 1); cyc();
        flush = 1;
        push("fl_take", 1, 1, 1, 0, 32'h80000007, 32'h90, 32'h0, 32'h100); cyc();
        flush = 0; mip = '0;
        // Reset while ARMED drops the take
        mip.mtip = 1;
        push("rs_req", 0, 0, 0, 1); cyc();
        rst_n = 0; mip = '0;
        push("rs_in", 0, 0, 0, 0); cyc();
        rst_n = 1; mip.mtip = 1;
        push("rs_idle", 0, 0, 0, 1); cyc();
        push("rs_take", 1, 1, 1, 0, 32'h80000007, 32'h90, 32'h0, 32'h100); cyc();
        mip = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
